// File: rtl/multdiv_unit.sv
// Sequential signed 32x32 multiply / divide beside the ALU: one bit per clock,
// 32 iterations plus a sign fix-up cycle, then a one-cycle ready pulse.
module multdiv_unit (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q;
    logic        neg_q, dz_q, ovf_q;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d, rdy_q, rdy_d;

    logic        start;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [31:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] prod;
    logic [31:0] quo;

    assign start = ctrl_MULT | ctrl_DIV;
    assign abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // Multiply: acc = {partial high, multiplier}; add on LSB, shift right.
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Divide: acc = {remainder, dividend bits}; the remainder stays below the
    // divisor, so twice it plus one bit always fits in 32 bits.
    assign div_shift = {acc_q[62:32], acc_q[31]};
    assign div_diff  = {1'b0, div_shift} - {1'b0, opnd_q};
    assign prod      = neg_q ? (~acc_q + 64'd1) : acc_q;
    assign quo       = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) state_q <= S_IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_MULT)     state_d = S_MUL;
        else if (ctrl_DIV) state_d = S_DIV;
        else begin
            case (state_q)
                S_MUL, S_DIV: if (cnt_q == 6'd32) state_d = S_DONE;
                S_DONE:       state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        res_d = res_q;
        exc_d = exc_q;
        rdy_d = 1'b0;
        if (start) begin
            acc_d = {32'd0, ctrl_MULT ? abs_b : abs_a};
            cnt_d = 6'd0;
        end else if (state_q == S_MUL || state_q == S_DIV) begin
            if (cnt_q != 6'd32) begin
                cnt_d = cnt_q + 6'd1;
                if (state_q == S_MUL) acc_d = {mul_sum, acc_q[31:1]};
                else if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                else acc_d = {div_shift, acc_q[30:0], 1'b0};
            end else begin
                rdy_d = 1'b1;
                if (state_q == S_MUL) begin
                    res_d = prod[31:0];
                    exc_d = ~((&prod[63:31]) | ~(|prod[63:31]));
                end else if (dz_q) begin
                    res_d = 32'd0;
                    exc_d = 1'b1;
                end else begin
                    res_d = quo;
                    exc_d = ovf_q;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            cnt_q  <= 6'd0;
            acc_q  <= 64'd0;
            opnd_q <= 32'd0;
            neg_q  <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            res_q  <= 32'd0;
            exc_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            res_q <= res_d;
            exc_q <= exc_d;
            rdy_q <= rdy_d;
            if (start) begin
                opnd_q <= ctrl_MULT ? abs_a : abs_b;
                neg_q  <= data_operandA[31] ^ data_operandB[31];
                dz_q   <= (data_operandB == 32'd0);
                ovf_q  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            end
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule
